// File: rtl/vc_input_buffer_pkg.sv
// Shared flit definition for the VC input buffer and the crossbar that consumes it.
package vc_input_buffer_pkg;

    localparam int FLIT_NUM_VCS = 2;
    // One spare bit so a write addressed past the last VC is representable and can be flagged.
    localparam int FLIT_VC_W    = $clog2(FLIT_NUM_VCS) + 1;
    localparam int FLIT_DATA_W  = 16;

    typedef struct packed {
        logic [FLIT_VC_W-1:0]   vc;
        logic [FLIT_DATA_W-1:0] data;
    } flit_t;

endpackage

// File: rtl/vc_input_buffer_fifo.sv
// Single-VC circular FIFO; pointers wrap modulo BUFFER_SIZE, occupancy kept in its own counter.
module vc_fifo
    import vc_input_buffer_pkg::*;
#(
    parameter int BUFFER_SIZE = 8
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             wen,
    input  flit_t                            wdata,
    input  logic                             ren,
    output flit_t                            rdata,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(BUFFER_SIZE+1)-1:0] count
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = $clog2(BUFFER_SIZE+1);

    flit_t            r_mem [BUFFER_SIZE];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUFFER_SIZE-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (r_count == '0);
    assign full    = (r_count == CNT_W'(BUFFER_SIZE));
    assign count   = r_count;
    assign w_do_rd = ren && !empty;
    // A full FIFO still accepts a write when its head leaves on the same edge.
    assign w_do_wr = wen && (!full || w_do_rd);
    assign rdata   = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_wr) r_wptr <= ptr_next(r_wptr);
            if (w_do_rd) r_rptr <= ptr_next(r_rptr);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wptr] <= wdata;
    end

endmodule

// File: rtl/vc_input_buffer.sv
// Per-port input buffer: one FIFO per VC, head flits to allocation, pops returned upstream as credits.
module vc_input_buffer
    import vc_input_buffer_pkg::*;
#(
    parameter int NUM_VCS      = FLIT_NUM_VCS,
    parameter int BUFFER_SIZE  = 8,
    parameter int BATCH_CREDIT = 0
) (
    input  logic                                          clk,
    input  logic                                          n_rst,
    input  flit_t                                         in_flit,
    input  logic                                          in_valid,
    output flit_t [NUM_VCS-1:0]                           out_flit,
    output logic  [NUM_VCS-1:0]                           out_valid,
    input  logic  [NUM_VCS-1:0]                           pop,
    output logic  [NUM_VCS-1:0]                           credit_granted,
    output logic  [NUM_VCS-1:0][$clog2(BUFFER_SIZE+1)-1:0] occupancy,
    output logic                                          overflow
);

    localparam int CNT_W = $clog2(BUFFER_SIZE+1);
    localparam int BATCH = 3 * BUFFER_SIZE / 4;

    logic               w_vc_ok;
    logic [NUM_VCS-1:0] w_wen;
    logic [NUM_VCS-1:0] w_full;
    logic [NUM_VCS-1:0] w_empty;
    logic [NUM_VCS-1:0] w_pop_eff;
    logic [NUM_VCS-1:0] w_drop;
    logic               r_overflow;

    assign w_vc_ok  = int'(in_flit.vc) < NUM_VCS;
    assign overflow = r_overflow;

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        logic r_cred;

        assign w_wen[v]     = in_valid && w_vc_ok && (int'(in_flit.vc) == v);
        assign w_pop_eff[v] = pop[v] && !w_empty[v];
        assign w_drop[v]    = w_wen[v] && w_full[v] && !pop[v];
        assign out_valid[v] = !w_empty[v];
        assign credit_granted[v] = r_cred;

        vc_fifo #(.BUFFER_SIZE(BUFFER_SIZE)) u_fifo (
            .clk   (clk),
            .n_rst (n_rst),
            .wen   (w_wen[v]),
            .wdata (in_flit),
            .ren   (pop[v]),
            .rdata (out_flit[v]),
            .full  (w_full[v]),
            .empty (w_empty[v]),
            .count (occupancy[v])
        );

        if (BATCH_CREDIT == 0) begin : g_single
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) r_cred <= 1'b0;
                else        r_cred <= w_pop_eff[v];
            end
        end else begin : g_batch
            logic [CNT_W-1:0] r_freed;
            logic [CNT_W-1:0] w_freed_nxt;

            assign w_freed_nxt = r_freed + CNT_W'(w_pop_eff[v]);

            // freed never exceeds BATCH-1 before the add, so subtracting BATCH always lands on zero.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    r_freed <= '0;
                    r_cred  <= 1'b0;
                end else if (w_freed_nxt == CNT_W'(BATCH)) begin
                    r_freed <= '0;
                    r_cred  <= 1'b1;
                end else begin
                    r_freed <= w_freed_nxt;
                    r_cred  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_overflow <= 1'b0;
        else        r_overflow <= r_overflow | (in_valid & ~w_vc_ok) | (|w_drop);
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: one instance per credit mode, shared stimulus, queue-based reference model.
module tb_vc_input_buffer;
    import vc_input_buffer_pkg::*;

    localparam int NV    = 2;
    localparam int BS    = 8;
    localparam int BATCH = 6;

    logic                clk = 1'b0;
    logic                n_rst;
    flit_t               in_flit;
    logic                in_valid;
    logic [NV-1:0]       pop;
    flit_t [NV-1:0]      of0, of1;
    logic [NV-1:0]       ov0, ov1, cr0, cr1;
    logic [NV-1:0][3:0]  oc0, oc1;
    logic                ovf0, ovf1;

    always #5 clk = ~clk;

    vc_input_buffer #(.NUM_VCS(NV), .BUFFER_SIZE(BS), .BATCH_CREDIT(0)) dut0 (
        .clk(clk), .n_rst(n_rst), .in_flit(in_flit), .in_valid(in_valid),
        .out_flit(of0), .out_valid(ov0), .pop(pop), .credit_granted(cr0),
        .occupancy(oc0), .overflow(ovf0));

    vc_input_buffer #(.NUM_VCS(NV), .BUFFER_SIZE(BS), .BATCH_CREDIT(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .in_flit(in_flit), .in_valid(in_valid),
        .out_flit(of1), .out_valid(ov1), .pop(pop), .credit_granted(cr1),
        .occupancy(oc1), .overflow(ovf1));

    int            n_checks = 0;
    int            n_errors = 0;
    logic [15:0]   q[NV][$];
    int            freed[NV];
    logic [NV-1:0] exp_c0, exp_c1;
    logic          exp_ovf;
    int            pulses0[NV], pulses1[NV];

    typedef struct {
        logic        iv;
        logic [1:0]  vc;
        logic [15:0] d;
        logic [1:0]  pop;
        logic        e_valid;
        logic [15:0] e_head;
        logic [3:0]  e_occ;
        logic        e_cred;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            q[v].delete();
            freed[v]   = 0;
            pulses0[v] = 0;
            pulses1[v] = 0;
        end
        exp_c0  = '0;
        exp_c1  = '0;
        exp_ovf = 1'b0;
    endtask

    task automatic compare_model();
        flit_t [NV-1:0]     ef;
        logic [NV-1:0]      ev;
        logic [NV-1:0][3:0] eo;
        for (int v = 0; v < NV; v++) begin
            ev[v] = q[v].size() > 0;
            eo[v] = 4'(q[v].size());
            ef[v] = '0;
            if (ev[v]) ef[v] = '{vc: 2'(v), data: q[v][0]};
        end
        chk("valid_m0", ov0, ev);    chk("valid_m1", ov1, ev);
        chk("flit_m0", of0, ef);     chk("flit_m1", of1, ef);
        chk("occ_m0", oc0, eo);      chk("occ_m1", oc1, eo);
        chk("ovf_m0", ovf0, exp_ovf); chk("ovf_m1", ovf1, exp_ovf);
        chk("credit_m0", cr0, exp_c0); chk("credit_m1", cr1, exp_c1);
        for (int v = 0; v < NV; v++) begin
            if (cr0[v]) pulses0[v]++;
            if (cr1[v]) pulses1[v]++;
        end
    endtask

    // Called at a negedge: drive inputs, advance the model, cross one edge, compare.
    task automatic step(input logic iv, input logic [1:0] ivc, input logic [15:0] d, input logic [1:0] p);
        logic acc;
        logic eff;
        in_valid = iv;
        in_flit  = '{vc: ivc, data: d};
        pop      = p;
        acc      = 1'b0;
        if (iv) begin
            if (int'(ivc) >= NV)                                   exp_ovf = 1'b1;
            else if (q[int'(ivc)].size() == BS && !p[int'(ivc)])   exp_ovf = 1'b1;
            else                                                   acc = 1'b1;
        end
        for (int v = 0; v < NV; v++) begin
            eff = p[v] && (q[v].size() > 0);
            if (eff) void'(q[v].pop_front());
            exp_c0[v] = eff;
            freed[v] += eff ? 1 : 0;
            exp_c1[v] = (freed[v] == BATCH);
            if (exp_c1[v]) freed[v] -= BATCH;
        end
        if (acc) q[int'(ivc)].push_back(d);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        pop      = '0;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst    = 1'b0;
        in_valid = 1'b0;
        pop      = '0;
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        model_reset();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {ov1, ov0}, '0);
        chk({tag, "_flit"}, {of1, of0}, '0);
        chk({tag, "_occ"}, {oc1, oc0}, '0);
        chk({tag, "_cred"}, {cr1, cr0}, '0);
        chk({tag, "_ovf"}, {ovf1, ovf0}, '0);
    endtask

    initial begin
        n_rst    = 1'b0;
        in_valid = 1'b0;
        in_flit  = '0;
        pop      = '0;
        model_reset();

        tbl[0] = '{1'b1, 2'd1, 16'h000A, 2'b00, 1'b1, 16'h000A, 4'd1, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 16'h000B, 2'b00, 1'b1, 16'h000A, 4'd2, 1'b0};
        tbl[2] = '{1'b1, 2'd1, 16'h000C, 2'b00, 1'b1, 16'h000A, 4'd3, 1'b0};
        tbl[3] = '{1'b0, 2'd0, 16'h0000, 2'b10, 1'b1, 16'h000B, 4'd2, 1'b1};
        tbl[4] = '{1'b0, 2'd0, 16'h0000, 2'b10, 1'b1, 16'h000C, 4'd1, 1'b1};
        tbl[5] = '{1'b0, 2'd0, 16'h0000, 2'b10, 1'b0, 16'h0000, 4'd0, 1'b1};
        tbl[6] = '{1'b0, 2'd0, 16'h0000, 2'b00, 1'b0, 16'h0000, 4'd0, 1'b0};

        // Reset state
        #12;
        chk_all_zero("reset");
        do_reset();

        // Ordered write/pop on VC1
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].iv, tbl[i].vc, tbl[i].d, tbl[i].pop);
            chk($sformatf("tbl%0d_valid", i), ov0[1], tbl[i].e_valid);
            chk($sformatf("tbl%0d_head", i), of0[1].data, tbl[i].e_head);
            chk($sformatf("tbl%0d_occ", i), oc0[1], tbl[i].e_occ);
            chk($sformatf("tbl%0d_cred", i), cr0[1], tbl[i].e_cred);
        end

        // Batched credit: 6 pops per pulse, residual held
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 16'h0200 + 16'(i), 2'b00);
        for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 16'h0, 2'b01);
        chk("batch_5pops", pulses1[0], 0);
        step(1'b0, 2'd0, 16'h0, 2'b01);
        chk("batch_6pops", pulses1[0], 1);
        step(1'b0, 2'd0, 16'h0, 2'b01);
        step(1'b0, 2'd0, 16'h0, 2'b01);
        step(1'b0, 2'd0, 16'h0, 2'b00);
        chk("batch_8pops", pulses1[0], 1);
        chk("single_8pops", pulses0[0], 8);

        // Overflow on full VC, then full VC with simultaneous pop
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 16'h0300 + 16'(i), 2'b00);
        step(1'b1, 2'd0, 16'h03FF, 2'b00);
        chk("full_drop_ovf", ovf0, 1'b1);
        chk("full_drop_occ", oc0[0], 4'd8);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 16'h0400 + 16'(i), 2'b00);
        step(1'b1, 2'd0, 16'h04FF, 2'b01);
        chk("full_pop_ovf", ovf0, 1'b0);
        chk("full_pop_occ", oc0[0], 4'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 16'h0, 2'b01);

        // Write to a nonexistent VC
        do_reset();
        step(1'b1, 2'd3, 16'h0555, 2'b00);
        chk("bad_vc_ovf", ovf0, 1'b1);
        chk("bad_vc_occ", oc0, 8'h00);

        // Interleaved VCs with dual pops
        do_reset();
        for (int i = 0; i < 12; i++)
            step(1'b1, 2'(i % 2), 16'h0600 + 16'(i), (i >= 3) ? 2'b11 : 2'b00);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 16'h0, 2'b11);

        // Pointer wrap on VC1
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 2'd1, 16'h0700 + 16'(i), 2'b00);
            step(1'b0, 2'd0, 16'h0, 2'b10);
        end
        chk("wrap_single_credits", pulses0[1], 20);
        chk("wrap_batch_credits", pulses1[1], 3);

        // Asynchronous reset mid-operation discards flits and partial credit
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 2'd0, 16'h0800 + 16'(i), 2'b00);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 16'h0, 2'b01);
        #2 n_rst = 1'b0;
        #1 chk_all_zero("midreset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 2'd0, 16'h0900 + 16'(i), 2'b00);
        for (int i = 0; i < 6; i++) step(1'b0, 2'd0, 16'h0, 2'b01);
        step(1'b0, 2'd0, 16'h0, 2'b00);
        chk("post_reset_batch", pulses1[0], 1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [1:0] rvc;
            rvc = ($urandom_range(0, 31) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
            step(($urandom_range(0, 3) != 0), rvc, 16'($urandom),
                 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vc_input_buffer.md
# vc_input_buffer

Receive-side input buffer for one switch port. It stores incoming flits in per-virtual-channel FIFOs and presents each VC's head flit to switch allocation. Each pop is returned upstream as a credit pulse, so the upstream crossbar's per-VC availability counters stay coherent. It sits between a link/crossbar output and the local crossbar input, and closes the credit loop that the crossbar's `credit_granted` inputs consume.

## Interface
Parameters:
- `NUM_VCS`, 2: number of virtual channels.
- `BUFFER_SIZE`, 8: flit slots per VC. Must be ≥ 4 and divisible by 4.
- `BATCH_CREDIT`, 0: 0 → one credit pulse per popped flit; 1 → one credit pulse per `3*BUFFER_SIZE/4` popped flits. Matches the crossbar's port-0 and non-zero-port credit weights respectively.

Ports:
- `clk`  in  1  clock.
- `n_rst`  in  1  asynchronous, active-low reset.
- `in_flit`  in  `flit_t`  incoming flit; `in_flit.vc` selects the FIFO.
- `in_valid`  in  1  write `in_flit` this cycle.
- `out_flit`  out  `[NUM_VCS-1:0] flit_t`  head flit of each VC FIFO; `'0` when that VC is empty.
- `out_valid`  out  `[NUM_VCS-1:0]`  VC FIFO non-empty.
- `pop`  in  `[NUM_VCS-1:0]`  remove the head of each VC. Multiple VCs may pop in one cycle.
- `credit_granted`  out  `[NUM_VCS-1:0]`  registered single-cycle credit pulse per VC.
- `occupancy`  out  `[NUM_VCS-1:0][$clog2(BUFFER_SIZE+1)-1:0]`  current entries per VC.
- `overflow`  out  1  sticky error; set when a write targets a full VC.

## Operation
- Write: on `in_valid`, `in_flit` is enqueued in FIFO `in_flit.vc`.
  - If that FIFO is full and not popping this cycle, the flit is dropped and `overflow` is set.
  - `overflow` clears only on reset.
- Write with `in_flit.vc ≥ NUM_VCS`: dropped, and `overflow` is set.
- Pop: `pop[v]` with `out_valid[v]=1` removes the head at the clock edge. `pop[v]` on an empty VC is ignored and produces no credit.
- Simultaneous write and pop on the same VC is legal, including when the FIFO is full. Occupancy is unchanged, and the popped flit produces credit.
- FIFO storage is a circular buffer: read and write pointers wrap modulo `BUFFER_SIZE`, and occupancy is tracked separately. FIFO order is preserved per VC; there is no ordering between VCs.
- Credit, `BATCH_CREDIT=0`: each effective pop on VC v drives `credit_granted[v]=1` on the following cycle.
- Credit, `BATCH_CREDIT=1`: a per-VC `freed` counter increments on each effective pop.
  - When `freed` reaches `BATCH = 3*BUFFER_SIZE/4`, `credit_granted[v]` pulses the next cycle and `freed` is decremented by `BATCH` in the same update.
  - Residual frees below `BATCH` are held, not flushed.
  - Counter width is `$clog2(BUFFER_SIZE+1)`; no saturation is needed because `freed < BATCH` after every update.

## Timing
- Reset values: `out_valid='0`, `out_flit='0`, `credit_granted='0`, `occupancy='0`, `overflow=0`, all pointers and `freed` counters 0. Reset is effective immediately on `n_rst` falling.
- Reset mid-operation discards all stored flits and pending partial credit.
- Write latency: a flit written at edge k is visible on `out_flit`/`out_valid` after edge k. There is no bypass to the same-cycle output.
- `out_flit` and `out_valid` are combinational from registered FIFO state and do not depend on `pop`.
- Credit latency: exactly 1 cycle after the pop edge (registered). At most one pulse per VC per cycle.
- `occupancy` updates at the same edge as the write or pop.

## Structure
- Shared package holds `flit_t` (including the `vc` field) and the `NUM_VCS`-dependent VC index width. The flit type is the same one the crossbar consumes.
- Sub-module `vc_fifo`: a single-VC circular FIFO with `wen`/`ren`/`full`/`empty`/`count`, parameterized by `BUFFER_SIZE`. It is instantiated `NUM_VCS` times.
- Credit generation stays in the top-level module.

## Test plan
- Reset, then write 3 flits to VC1 (payloads A, B, C); pop VC1 three times → `out_flit[1]` reads A, B, C in order; with `BATCH_CREDIT=0`, `credit_granted[1]` pulses on 3 consecutive cycles, one cycle after each pop; `occupancy[1]` reads 3, 2, 1, 0.
- `BATCH_CREDIT=1`, `BUFFER_SIZE=8`: fill VC0 with 8 flits, pop 5 → no credit; 6th pop → single `credit_granted[0]` pulse the next cycle; pop 2 more → no further pulse, with `freed=2` retained.
- Fill VC0 to 8, then write a 9th flit without a pop → flit dropped, `overflow=1`, `occupancy[0]=8`. Repeat on a fresh reset with a simultaneous pop → accepted, `occupancy[0]` stays 8, `overflow=0`.
- Interleave writes to VC0 and VC1 while popping both in the same cycle → independent per-VC order and credits; no cross-VC leakage.
- Pointer wrap: 20 write/pop pairs on VC1 with `BUFFER_SIZE=8` → data order correct across wrap; 20 credits with `BATCH_CREDIT=0`.
- Assert `n_rst` low with 4 flits in VC0 and `freed=3` → all outputs 0 immediately; after release, the first 6 pops yield exactly one credit.
